// File: rtl/alu_op_pkg.sv
// Shared types for the ALU operation engine: opcode encoding and control states.
package alu_op_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_MUL_BUSY = 2'b01,
        ST_DONE     = 2'b10
    } alu_state_e;

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, always WIDTH steps.
module alu_iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic             UserCLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             busy_q,   busy_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] acc_step;

    // No early exit on a zero multiplier, so latency never depends on data.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // The final step's sum is offered combinationally so the owner can capture it on that edge.
    assign busy       = busy_q;
    assign done       = busy_q && (cnt_q == LAST_STEP);
    assign product_lo = acc_step;

endmodule

// File: rtl/alu_op_engine.sv
// Single-slot ALU engine: one-cycle logic/add ops, WIDTH-cycle iterative multiply,
// valid/ready on both sides with a registered result slot.
module alu_op_engine
    import alu_op_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             UserCLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_err
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_err_q, out_err_d;

    logic             accept;
    logic             out_hs;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .UserCLK    (UserCLK),
        .rst_n      (rst_n),
        .start      (mul_start),
        .a          (in_a),
        .b          (in_b),
        .busy       (mul_busy),
        .done       (mul_done),
        .product_lo (mul_product)
    );

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (in_op)
            OP_ADD:  alu_y = in_a + in_b;
            OP_SUB:  alu_y = in_a - in_b;
            OP_AND:  alu_y = in_a & in_b;
            OP_OR:   alu_y = in_a | in_b;
            OP_XOR:  alu_y = in_a ^ in_b;
            OP_MUL:  alu_y = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        out_y_d   = out_y_q;
        out_err_d = out_err_q;
        mul_start = 1'b0;
        in_ready  = 1'b0;

        case (state_q)
            ST_IDLE:     in_ready = !mul_busy;
            ST_MUL_BUSY: in_ready = 1'b0;
            ST_DONE:     in_ready = out_ready && !mul_busy;
            default:     in_ready = 1'b0;
        endcase

        accept = in_valid && in_ready;
        out_hs = (state_q == ST_DONE) && out_ready;

        if (out_hs) begin
            state_d = ST_IDLE;
        end

        if ((state_q == ST_MUL_BUSY) && mul_done) begin
            state_d   = ST_DONE;
            out_y_d   = mul_product;
            out_err_d = 1'b0;
        end

        // A new accept overrides the drain-to-IDLE so back-to-back traffic has no bubble.
        if (accept) begin
            if (op_is_mul(in_op)) begin
                mul_start = 1'b1;
                state_d   = ST_MUL_BUSY;
            end else begin
                state_d   = ST_DONE;
                out_y_d   = alu_y;
                out_err_d = alu_err;
            end
        end
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_y_q   <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_y_q   <= out_y_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out_y     = out_y_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_op_engine.sv
// Scoreboard bench for alu_op_engine: directed stimulus pushes expectations,
// an independent monitor pops and compares at every output handshake.
module tb_alu_op_engine;

    logic        UserCLK;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_err;

    typedef struct {
        logic [31:0] y;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    alu_op_engine #(.WIDTH(32)) dut (
        .UserCLK   (UserCLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_err   (out_err)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    initial cyc = 0;
    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] y, input logic err, input int lat);
        int w;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        w        = 0;
        #1;
        while (!in_ready && w < 100) begin
            @(negedge UserCLK);
            #1;
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 100 cycles");
            in_valid = 1'b0;
        end else begin
            sb.push_back('{y: y, err: err, cyc: (lat < 0) ? -1 : cyc + lat});
            @(negedge UserCLK);
        end
    endtask

    // Monitor: the handshake edge samples the same values seen here.
    initial begin
        exp_t e;
        forever begin
            @(negedge UserCLK);
            #1;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got y=%h err=%b, expected no result", out_y, out_err);
                end else begin
                    e = sb.pop_front();
                    chk("out_y", out_y, e.y);
                    chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                    if (e.cyc >= 0) chk("result_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        exp_t dropped;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_op = 3'b000;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge UserCLK);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_err", {31'b0, out_err}, 0);
        @(negedge UserCLK);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        @(negedge UserCLK);

        // Single-cycle ops with wrap
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge UserCLK);
        issue(3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge UserCLK);
        issue(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge UserCLK);

        // MUL: in_ready low for 32 cycles, operand churn ignored
        issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
        in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            in_a  = $urandom;
            in_b  = $urandom;
            in_op = 3'($urandom_range(0, 7));
            #1;
            chk("mul_in_ready_low", {31'b0, in_ready}, 0);
            @(negedge UserCLK);
        end
        repeat (3) @(negedge UserCLK);

        // MUL latency is data-independent
        issue(3'b101, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 33);
        in_valid = 1'b0;
        repeat (35) @(negedge UserCLK);
        issue(3'b101, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 33);
        in_valid = 1'b0;
        repeat (35) @(negedge UserCLK);

        // Back-to-back, one result per cycle
        issue(3'b000, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1);
        issue(3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1);
        issue(3'b011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
        issue(3'b110, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1);
        issue(3'b111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1);
        in_valid = 1'b0;
        repeat (3) @(negedge UserCLK);

        // Consumer stall, then handshake together with a pending MUL
        out_ready = 1'b0;
        issue(3'b000, 32'd100, 32'd23, 32'd123, 1'b0, -1);
        in_op = 3'b101;
        in_a  = 32'd3;
        in_b  = 32'd7;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_out_valid", {31'b0, out_valid}, 1);
            chk("stall_out_y", out_y, 32'd123);
            chk("stall_in_ready", {31'b0, in_ready}, 0);
            @(negedge UserCLK);
        end
        out_ready = 1'b1;
        issue(3'b101, 32'd3, 32'd7, 32'd21, 1'b0, 33);
        in_valid = 1'b0;
        repeat (35) @(negedge UserCLK);

        // Reset mid-MUL discards the operation
        issue(3'b101, 32'd3, 32'd5, 32'd15, 1'b0, 33);
        in_valid = 1'b0;
        repeat (9) @(negedge UserCLK);
        rst_n = 1'b0;
        dropped = sb.pop_back();
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        @(negedge UserCLK);
        rst_n = 1'b1;
        #1;
        chk("postrst_out_valid", {31'b0, out_valid}, 0);
        chk("postrst_in_ready", {31'b0, in_ready}, 1);
        chk("postrst_out_y", out_y, 0);
        repeat (40) @(negedge UserCLK);
        issue(3'b000, 32'd7, 32'd8, 32'd15, 1'b0, 1);
        in_valid = 1'b0;

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge UserCLK);
            w++;
        end
        repeat (2) @(negedge UserCLK);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_engine.md
ALU_OP_ENGINE -- requirements
Module: alu_op_engine

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Port UserCLK  input  1: single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1: asynchronous, active-low reset.
REQ-004 Port in_valid  input  1: operand/opcode presented.
REQ-005 Port in_ready  output  1: engine accepts the operands this cycle.
REQ-006 Port in_op  input  3: opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 illegal).
REQ-007 Port in_a  input  WIDTH: operand A.
REQ-008 Port in_b  input  WIDTH: operand B.
REQ-009 Port out_valid  output  1: result held on out_y/out_err.
REQ-010 Port out_ready  input  1: consumer takes the result.
REQ-011 Port out_y  output  WIDTH: result.
REQ-012 Port out_err  output  1: result came from an illegal opcode.

Function
REQ-013 The engine SHALL hold at most one operation in flight and one result.
REQ-014 States SHALL be IDLE, MUL_BUSY and DONE.
REQ-015 Handshake SHALL complete on in_valid and in_ready both high at the rising edge; the same rule applies to out_valid and out_ready.
REQ-016 in_ready SHALL be high in IDLE, low in MUL_BUSY, and equal to out_ready in DONE.
REQ-017 Accept of ADD/SUB/AND/OR/XOR/illegal SHALL register out_y and enter DONE, so out_valid is high exactly one cycle after accept.
REQ-018 ADD/SUB SHALL be modulo 2^WIDTH, with wrap-around and no carry or borrow output.
REQ-019 AND/OR/XOR SHALL be bitwise.
REQ-020 An illegal opcode SHALL give out_y = 0 and out_err = 1; every legal op SHALL give out_err = 0.
REQ-021 MUL accept SHALL latch the operands and enter MUL_BUSY.
- The engine SHALL perform one shift-add step per cycle, over WIDTH steps.
- It SHALL then enter DONE, with out_valid high exactly WIDTH+1 cycles after accept.
REQ-022 The MUL result SHALL be the low WIDTH bits of A*B, which is identical for signed and unsigned operands.
REQ-023 In DONE, out_y/out_err SHALL stay stable until the output handshake.
REQ-024 Output handshake with no input accept SHALL return to IDLE.
REQ-025 Output handshake with a simultaneous input accept SHALL load the new operation in the same cycle, with no bubble.
- The next state SHALL be DONE for non-MUL ops.
- The next state SHALL be MUL_BUSY for MUL.
REQ-026 Inputs SHALL be ignored whenever in_ready is low; in_a, in_b and in_op changes during MUL_BUSY SHALL NOT affect the result.
REQ-027 MUL with either operand 0 SHALL still take the full WIDTH+1 cycle latency, so latency is data-independent.

Reset
REQ-028 Asserting rst_n low SHALL immediately set state to IDLE and clear the step counter.
REQ-029 Reset SHALL drive out_valid = 0, out_y = 0 and out_err = 0.
REQ-030 Reset in MUL_BUSY or DONE SHALL discard the operation with no result emitted.
REQ-031 After release, in_ready SHALL be high in the first cycle.

Structure
REQ-032 Package alu_op_pkg SHALL hold the opcode enum, the state enum and the opcode width constant (3).
REQ-033 The shift-add multiplier SHALL be sub-module alu_iter_mul.
- Ports: start, a, b, busy, done, product_lo.
- It SHALL contain a $clog2(WIDTH+1)-bit step counter.

Verification
REQ-034 ADD 0xFFFFFFFF + 0x00000002, out_ready = 1: out_y = 0x00000001 and out_err = 0, one cycle after accept.
REQ-035 SUB 0x00000000 - 0x00000001 -> out_y = 0xFFFFFFFF; XOR 0xF0F0F0F0 ^ 0xFF00FF00 -> out_y = 0x0FF00FF0.
REQ-036 MUL 0xFFFFFFFF * 0xFFFFFFFF -> out_y = 0x00000001 at cycle 33 after accept.
- in_ready SHALL be low for cycles 1..32.
- Operand changes mid-operation SHALL have no effect.
REQ-037 Back-to-back traffic, out_ready held high, in_valid always high: ADD, AND, OR, op 110 -> one result per cycle.
- Expected out_err sequence: 0, 0, 0, 1.
REQ-038 out_ready low for 5 cycles in DONE -> out_y held stable and in_ready low.
- Then raise out_ready together with a pending MUL 3*7 -> MUL accepted in the handshake cycle, out_y = 21 after 33 more cycles.
REQ-039 rst_n pulsed low at cycle 10 of a MUL -> out_valid = 0 and in_ready = 1 after release; no stale result ever appears.
